// File: rtl/fft_pkg.sv
// Shared FFT datapath definitions: butterfly mode, pipeline depth and the
// round/shift/saturate helper used by every FFT stage.
package fft_pkg;

    typedef enum logic {
        BF_DIF = 1'b0,
        BF_DIT = 1'b1
    } bf_mode_e;

    localparam int BF_LATENCY = 4;

    // Working width of sat_round; wide enough for any stage product.
    localparam int SR_W = 64;

    typedef struct packed {
        logic [SR_W-1:0] value;
        logic            clipped;
    } sat_res_t;

    // Round half up (when round_en and shift > 0), arithmetic shift right,
    // then clamp to a signed out_w-bit range.
    function automatic sat_res_t sat_round(
        input logic signed [SR_W-1:0] value,
        input logic [31:0]            shift,
        input logic                   round_en,
        input int unsigned            out_w
    );
        logic signed [SR_W-1:0] v;
        logic signed [SR_W-1:0] hi;
        logic signed [SR_W-1:0] lo;
        sat_res_t               res;
        v = value;
        if (round_en && shift != 32'd0) begin
            v = v + (SR_W'(1) <<< (shift - 32'd1));
        end
        v  = v >>> shift;
        hi = (SR_W'(1) <<< (out_w - 1)) - SR_W'(1);
        lo = -(SR_W'(1) <<< (out_w - 1));
        if (v > hi) begin
            res.value   = hi;
            res.clipped = 1'b1;
        end else if (v < lo) begin
            res.value   = lo;
            res.clipped = 1'b1;
        end else begin
            res.value   = v;
            res.clipped = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/butterfly_pipe_if.sv
// Operand/result stream bundle of the radix-2 butterfly; slave is the
// butterfly side, master the producer/consumer side.
interface butterfly_pipe_if
    import fft_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int TW_W   = 16
);
    logic                     in_valid;
    logic                     in_ready;
    bf_mode_e                 mode;
    logic                     scale;
    logic signed [DATA_W-1:0] a_r;
    logic signed [DATA_W-1:0] a_i;
    logic signed [DATA_W-1:0] b_r;
    logic signed [DATA_W-1:0] b_i;
    logic signed [TW_W-1:0]   w_r;
    logic signed [TW_W-1:0]   w_i;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] x_r;
    logic signed [DATA_W-1:0] x_i;
    logic signed [DATA_W-1:0] y_r;
    logic signed [DATA_W-1:0] y_i;
    logic                     ovf;
    logic                     ovf_clr;

    modport slave (
        input  in_valid, mode, scale, a_r, a_i, b_r, b_i, w_r, w_i,
        input  out_ready, ovf_clr,
        output in_ready, out_valid, x_r, x_i, y_r, y_i, ovf
    );

    modport master (
        output in_valid, mode, scale, a_r, a_i, b_r, b_i, w_r, w_i,
        output out_ready, ovf_clr,
        input  in_ready, out_valid, x_r, x_i, y_r, y_i, ovf
    );
endinterface

// File: rtl/cmult_pipe.sv
// Two-stage registered complex multiplier: partial products, then the
// add/sub, both at full precision and both gated by i_en.
module cmult_pipe #(
    parameter int   IN_W = 17,
    parameter int   TW_W = 16,
    localparam int  P_W  = IN_W + TW_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_en,
    input  logic signed [IN_W-1:0] i_b_r,
    input  logic signed [IN_W-1:0] i_b_i,
    input  logic signed [TW_W-1:0] i_w_r,
    input  logic signed [TW_W-1:0] i_w_i,
    output logic signed [P_W-1:0]  o_p_r,
    output logic signed [P_W-1:0]  o_p_i
);
    logic signed [P_W-1:0] r_rr;
    logic signed [P_W-1:0] r_ii;
    logic signed [P_W-1:0] r_ri;
    logic signed [P_W-1:0] r_ir;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr  <= '0;
            r_ii  <= '0;
            r_ri  <= '0;
            r_ir  <= '0;
            o_p_r <= '0;
            o_p_i <= '0;
        end else if (i_en) begin
            r_rr  <= P_W'(i_b_r) * P_W'(i_w_r);
            r_ii  <= P_W'(i_b_i) * P_W'(i_w_i);
            r_ri  <= P_W'(i_b_r) * P_W'(i_w_i);
            r_ir  <= P_W'(i_b_i) * P_W'(i_w_r);
            // Input range (|b| < 2^(IN_W-1), |w| <= 2^(TW_W-1)) keeps these sums in P_W bits.
            o_p_r <= r_rr - r_ii;
            o_p_i <= r_ri + r_ir;
        end
    end
endmodule

// File: rtl/butterfly_pipe.sv
// Four-stage radix-2 butterfly with run-time DIF/DIT, optional halving,
// round-half-up, saturation, sticky overflow and a global stall.
module butterfly_pipe
    import fft_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int TW_W   = 16
) (
    input  logic            clk,
    input  logic            reset,
    butterfly_pipe_if.slave bus
);
    localparam int S_W = DATA_W + 1;
    localparam int V_W = DATA_W + 2;
    localparam int P_W = S_W + TW_W;
    localparam logic signed [P_W-1:0] TW_HALF = P_W'(1) <<< (TW_W - 2);

    logic w_adv;
    logic w_acc;
    logic [BF_LATENCY-2:0] r_vld;
    logic r_out_valid;
    logic r_ovf;

    bf_mode_e r_s1_mode, r_s2_mode, r_s3_mode;
    logic     r_s1_scale, r_s2_scale, r_s3_scale;
    logic signed [DATA_W-1:0] r_s1_a_r, r_s1_a_i, r_s2_a_r, r_s2_a_i;
    logic signed [S_W-1:0]    r_s1_sum_r, r_s1_sum_i, r_s2_sum_r, r_s2_sum_i;
    logic signed [S_W-1:0]    r_s1_dif_r, r_s1_dif_i;
    logic signed [TW_W-1:0]   r_s1_w_r, r_s1_w_i;
    logic signed [V_W-1:0]    r_s3_x_r, r_s3_x_i, r_s3_y_r, r_s3_y_i;

    logic signed [S_W-1:0] w_b_ext_r, w_b_ext_i;
    logic signed [P_W-1:0] w_dit_p_r, w_dit_p_i, w_dif_p_r, w_dif_p_i;
    logic signed [S_W-1:0] w_t_r, w_t_i;

    logic signed [SR_W-1:0]   w_pre   [4];
    logic [31:0]              w_shift [4];
    sat_res_t                 w_res   [4];
    logic                     w_clip;
    logic signed [DATA_W-1:0] r_out   [4];

    assign w_adv        = !r_out_valid || bus.out_ready;
    assign w_acc        = bus.in_valid && w_adv;
    assign bus.in_ready = w_adv;

    assign w_b_ext_r = S_W'(bus.b_r);
    assign w_b_ext_i = S_W'(bus.b_i);

    // DIT multiplies B straight off the input; DIF multiplies the S1 difference.
    cmult_pipe #(.IN_W(S_W), .TW_W(TW_W)) u_cmult_dit (
        .clk   (clk),
        .rst   (reset),
        .i_en  (w_adv),
        .i_b_r (w_b_ext_r),
        .i_b_i (w_b_ext_i),
        .i_w_r (bus.w_r),
        .i_w_i (bus.w_i),
        .o_p_r (w_dit_p_r),
        .o_p_i (w_dit_p_i)
    );

    cmult_pipe #(.IN_W(S_W), .TW_W(TW_W)) u_cmult_dif (
        .clk   (clk),
        .rst   (reset),
        .i_en  (w_adv),
        .i_b_r (r_s1_dif_r),
        .i_b_i (r_s1_dif_i),
        .i_w_r (r_s1_w_r),
        .i_w_i (r_s1_w_i),
        .o_p_r (w_dif_p_r),
        .o_p_i (w_dif_p_i)
    );

    // DIT twiddle term is rounded back to S_W bits without saturation.
    assign w_t_r = S_W'((w_dit_p_r + TW_HALF) >>> (TW_W - 1));
    assign w_t_i = S_W'((w_dit_p_i + TW_HALF) >>> (TW_W - 1));

    always_comb begin
        w_pre[0]   = SR_W'(r_s3_x_r);
        w_pre[1]   = SR_W'(r_s3_x_i);
        w_shift[0] = {31'd0, r_s3_scale};
        w_shift[1] = {31'd0, r_s3_scale};
        if (r_s3_mode == BF_DIF) begin
            w_pre[2]   = SR_W'(w_dif_p_r);
            w_pre[3]   = SR_W'(w_dif_p_i);
            w_shift[2] = {31'd0, r_s3_scale} + 32'(TW_W - 1);
            w_shift[3] = {31'd0, r_s3_scale} + 32'(TW_W - 1);
        end else begin
            w_pre[2]   = SR_W'(r_s3_y_r);
            w_pre[3]   = SR_W'(r_s3_y_i);
            w_shift[2] = {31'd0, r_s3_scale};
            w_shift[3] = {31'd0, r_s3_scale};
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_sat
        assign w_res[gi] = sat_round(w_pre[gi], w_shift[gi], 1'b1, 32'(DATA_W));
    end

    assign w_clip = w_res[0].clipped | w_res[1].clipped | w_res[2].clipped | w_res[3].clipped;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vld       <= '0;
            r_out_valid <= 1'b0;
            r_ovf       <= 1'b0;
            r_s1_mode   <= BF_DIF;
            r_s2_mode   <= BF_DIF;
            r_s3_mode   <= BF_DIF;
            r_s1_scale  <= 1'b0;
            r_s2_scale  <= 1'b0;
            r_s3_scale  <= 1'b0;
            r_s1_a_r    <= '0;
            r_s1_a_i    <= '0;
            r_s2_a_r    <= '0;
            r_s2_a_i    <= '0;
            r_s1_sum_r  <= '0;
            r_s1_sum_i  <= '0;
            r_s2_sum_r  <= '0;
            r_s2_sum_i  <= '0;
            r_s1_dif_r  <= '0;
            r_s1_dif_i  <= '0;
            r_s1_w_r    <= '0;
            r_s1_w_i    <= '0;
            r_s3_x_r    <= '0;
            r_s3_x_i    <= '0;
            r_s3_y_r    <= '0;
            r_s3_y_i    <= '0;
            for (int k = 0; k < 4; k++) begin
                r_out[k] <= '0;
            end
        end else begin
            if (w_adv) begin
                r_vld       <= {r_vld[BF_LATENCY-3:0], w_acc};
                r_out_valid <= r_vld[BF_LATENCY-2];

                r_s1_mode  <= bus.mode;
                r_s1_scale <= bus.scale;
                r_s1_a_r   <= bus.a_r;
                r_s1_a_i   <= bus.a_i;
                r_s1_sum_r <= S_W'(bus.a_r) + S_W'(bus.b_r);
                r_s1_sum_i <= S_W'(bus.a_i) + S_W'(bus.b_i);
                r_s1_dif_r <= S_W'(bus.a_r) - S_W'(bus.b_r);
                r_s1_dif_i <= S_W'(bus.a_i) - S_W'(bus.b_i);
                r_s1_w_r   <= bus.w_r;
                r_s1_w_i   <= bus.w_i;

                r_s2_mode  <= r_s1_mode;
                r_s2_scale <= r_s1_scale;
                r_s2_a_r   <= r_s1_a_r;
                r_s2_a_i   <= r_s1_a_i;
                r_s2_sum_r <= r_s1_sum_r;
                r_s2_sum_i <= r_s1_sum_i;

                r_s3_mode  <= r_s2_mode;
                r_s3_scale <= r_s2_scale;
                if (r_s2_mode == BF_DIT) begin
                    r_s3_x_r <= V_W'(r_s2_a_r) + V_W'(w_t_r);
                    r_s3_x_i <= V_W'(r_s2_a_i) + V_W'(w_t_i);
                    r_s3_y_r <= V_W'(r_s2_a_r) - V_W'(w_t_r);
                    r_s3_y_i <= V_W'(r_s2_a_i) - V_W'(w_t_i);
                end else begin
                    r_s3_x_r <= V_W'(r_s2_sum_r);
                    r_s3_x_i <= V_W'(r_s2_sum_i);
                    r_s3_y_r <= '0;
                    r_s3_y_i <= '0;
                end

                if (r_vld[BF_LATENCY-2]) begin
                    for (int k = 0; k < 4; k++) begin
                        r_out[k] <= DATA_W'(w_res[k].value);
                    end
                end
            end

            if (w_adv && r_vld[BF_LATENCY-2] && w_clip) begin
                r_ovf <= 1'b1;
            end else if (bus.ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.ovf       = r_ovf;
    assign bus.x_r       = r_out[0];
    assign bus.x_i       = r_out[1];
    assign bus.y_r       = r_out[2];
    assign bus.y_i       = r_out[3];
endmodule

// File: tb/tb_butterfly_pipe.sv
// Directed bench for butterfly_pipe: an arithmetic reference model feeds a
// scoreboard checked every output cycle, plus literal spot values.
module tb_butterfly_pipe;
    import fft_pkg::*;

    localparam int DW = 16;
    localparam int TW = 16;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    butterfly_pipe_if #(.DATA_W(DW), .TW_W(TW)) bus ();

    butterfly_pipe #(.DATA_W(DW), .TW_W(TW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int a_r, a_i, b_r, b_i, w_r, w_i;
        bit mode, scale;
    } beat_t;

    typedef struct {
        int x_r, x_i, y_r, y_i;
        bit clip;
    } exp_t;

    exp_t  q[$];
    beat_t cur;
    int    n_checks = 0;
    int    n_pass   = 0;
    int    out_seen = 0;
    int    stall_cycles = 0;
    bit    hold_armed = 0;
    logic signed [DW-1:0] hold_v [4];

    task automatic chk(input string name, input longint act, input longint req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    function automatic beat_t mk(int ar, int ai, int br, int bi, int wr, int wi, bit md, bit sc);
        beat_t b;
        b.a_r = ar; b.a_i = ai; b.b_r = br; b.b_i = bi;
        b.w_r = wr; b.w_i = wi; b.mode = md; b.scale = sc;
        return b;
    endfunction

    function automatic longint rnd_sat(longint v, int sh, inout bit clip);
        longint r;
        r = v;
        if (sh > 0) r = r + (longint'(1) <<< (sh - 1));
        r = r >>> sh;
        if (r > 32767) begin r = 32767; clip = 1; end
        else if (r < -32768) begin r = -32768; clip = 1; end
        return r;
    endfunction

    // Reference: straight complex arithmetic on 64-bit integers.
    function automatic exp_t model(beat_t b);
        exp_t e;
        longint ar, ai, br, bi, wr, wi, dr, di, pr, pi, tr, ti;
        logic signed [DW:0] t17;
        bit c;
        c = 0;
        ar = b.a_r; ai = b.a_i; br = b.b_r; bi = b.b_i; wr = b.w_r; wi = b.w_i;
        if (!b.mode) begin
            dr = ar - br; di = ai - bi;
            pr = dr * wr - di * wi;
            pi = dr * wi + di * wr;
            e.x_r = int'(rnd_sat(ar + br, int'(b.scale), c));
            e.x_i = int'(rnd_sat(ai + bi, int'(b.scale), c));
            e.y_r = int'(rnd_sat(pr, TW - 1 + int'(b.scale), c));
            e.y_i = int'(rnd_sat(pi, TW - 1 + int'(b.scale), c));
        end else begin
            pr = br * wr - bi * wi;
            pi = br * wi + bi * wr;
            t17 = 17'((pr + 16384) >>> 15); tr = t17;
            t17 = 17'((pi + 16384) >>> 15); ti = t17;
            e.x_r = int'(rnd_sat(ar + tr, int'(b.scale), c));
            e.x_i = int'(rnd_sat(ai + ti, int'(b.scale), c));
            e.y_r = int'(rnd_sat(ar - tr, int'(b.scale), c));
            e.y_i = int'(rnd_sat(ai - ti, int'(b.scale), c));
        end
        e.clip = c;
        return e;
    endfunction

    // Compare process: handshakes are judged at the falling edge, where
    // inputs and registered outputs are stable for the coming rising edge.
    always @(negedge clk) begin
        if (reset) begin
            hold_armed = 0;
        end else begin
            if (bus.in_valid && bus.in_ready) q.push_back(model(cur));
            chk("in_ready_rule", longint'(bus.in_ready), longint'(!(bus.out_valid && !bus.out_ready)));
            if (!bus.in_ready) stall_cycles++;
            if (hold_armed && bus.out_valid) begin
                chk("hold_x_r", bus.x_r, hold_v[0]);
                chk("hold_x_i", bus.x_i, hold_v[1]);
                chk("hold_y_r", bus.y_r, hold_v[2]);
                chk("hold_y_i", bus.y_i, hold_v[3]);
            end
            hold_armed = bus.out_valid && !bus.out_ready;
            hold_v[0] = bus.x_r; hold_v[1] = bus.x_i;
            hold_v[2] = bus.y_r; hold_v[3] = bus.y_i;
            if (bus.out_valid && bus.out_ready) begin
                out_seen++;
                chk("beat_expected", longint'(q.size() > 0), 1);
                if (q.size() > 0) begin
                    exp_t e;
                    e = q.pop_front();
                    chk("model_x_r", bus.x_r, e.x_r);
                    chk("model_x_i", bus.x_i, e.x_i);
                    chk("model_y_r", bus.y_r, e.y_r);
                    chk("model_y_i", bus.y_i, e.y_i);
                    if (e.clip) chk("ovf_on_clip", longint'(bus.ovf), 1);
                end
            end
        end
    end

    task automatic send(input beat_t b);
        bit ok;
        ok = 0;
        cur = b;
        bus.in_valid = 1'b1;
        bus.mode  = b.mode ? BF_DIT : BF_DIF;
        bus.scale = b.scale;
        bus.a_r = DW'(b.a_r); bus.a_i = DW'(b.a_i);
        bus.b_r = DW'(b.b_r); bus.b_i = DW'(b.b_i);
        bus.w_r = TW'(b.w_r); bus.w_i = TW'(b.w_i);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (bus.in_ready) begin ok = 1; break; end
        end
        if (!ok) chk("send_timeout", 0, 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    // One isolated beat: checks the 4-cycle latency and literal results.
    task automatic run_one(input beat_t b, input int exr, input int exi,
                           input int eyr, input int eyi, input string tag);
        int lat;
        bit got;
        got = 0;
        lat = 0;
        send(b);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus.out_valid) begin got = 1; lat = k; break; end
        end
        chk({tag, "_latency"}, lat, BF_LATENCY);
        if (got) begin
            chk({tag, "_x_r"}, bus.x_r, exr);
            chk({tag, "_x_i"}, bus.x_i, exi);
            chk({tag, "_y_r"}, bus.y_r, eyr);
            chk({tag, "_y_i"}, bus.y_i, eyi);
        end
        @(posedge clk); #1;
    endtask

    beat_t bp [8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        bus.in_valid = 0; bus.out_ready = 1; bus.ovf_clr = 0;
        bus.mode = BF_DIF; bus.scale = 0;
        bus.a_r = 0; bus.a_i = 0; bus.b_r = 0; bus.b_i = 0; bus.w_r = 0; bus.w_i = 0;
        cur = mk(0, 0, 0, 0, 0, 0, 0, 0);

        bp[0] = mk(1000, 200, 400, -100, 32767, 0, 0, 0);
        bp[1] = mk(-5000, 7000, 3000, -2000, 23170, -23170, 0, 1);
        bp[2] = mk(12000, -3000, -8000, 4000, 23170, -23170, 1, 0);
        bp[3] = mk(30000, 30000, 20000, -20000, 0, -32768, 1, 0);
        bp[4] = mk(-32768, -32768, 32767, 32767, -32768, 0, 0, 0);
        bp[5] = mk(100, -100, 50, 25, -23170, 23170, 1, 1);
        bp[6] = mk(-20000, 15000, -20000, -15000, 32767, 0, 0, 1);
        bp[7] = mk(7, -7, 3, -3, 12540, -30274, 1, 1);

        repeat (3) @(posedge clk); #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_x_r", bus.x_r, 0);
        chk("rst_y_i", bus.y_i, 0);
        chk("rst_ovf", bus.ovf, 0);
        reset = 0;
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1);
        @(posedge clk); #1;

        run_one(mk(1000, 200, 400, -100, 32767, 0, 0, 0), 1400, 100, 600, 300, "dif_unity");
        run_one(mk(1000, 200, 400, -100, 0, -32768, 1, 0), 900, -200, 1100, 600, "dit_mj");
        chk("ovf_idle", bus.ovf, 0);
        run_one(mk(30000, 0, 10000, 0, 32767, 0, 0, 0), 32767, 0, 19999, 0, "sat");
        chk("ovf_set", bus.ovf, 1);
        run_one(mk(1000, 200, 400, -100, 32767, 0, 0, 0), 1400, 100, 600, 300, "after_sat");
        chk("ovf_sticky", bus.ovf, 1);
        bus.ovf_clr = 1;
        @(posedge clk); #1;
        bus.ovf_clr = 0;
        chk("ovf_cleared", bus.ovf, 0);
        run_one(mk(30000, 0, 10000, 0, 32767, 0, 0, 1), 20000, 0, 10000, 0, "scaled");
        chk("ovf_scaled", bus.ovf, 0);
        run_one(mk(0, 0, -32768, 0, -32768, 0, 1, 0), 32767, 0, -32768, 0, "w_minus1");
        chk("ovf_w_minus1", bus.ovf, 1);

        // Back-to-back stream with three cycles of downstream stall.
        stall_cycles = 0;
        out_seen = 0;
        fork
            begin
                for (int i = 0; i < 8; i++) send(bp[i]);
            end
            begin
                repeat (6) @(posedge clk); #1;
                bus.out_ready = 0;
                repeat (3) @(posedge clk); #1;
                bus.out_ready = 1;
            end
        join
        for (int k = 0; k < 100 && out_seen < 8; k++) @(negedge clk);
        chk("bp_out_count", out_seen, 8);
        chk("bp_stall_cycles", stall_cycles, 3);
        chk("bp_queue_empty", q.size(), 0);
        @(posedge clk); #1;

        // Reset with beats in flight: nothing must emerge afterwards.
        for (int i = 0; i < 4; i++) send(bp[i]);
        chk("mid_out_valid_pre", bus.out_valid, 1);
        reset = 1;
        q.delete();
        #1;
        chk("mid_out_valid_drop", bus.out_valid, 0);
        chk("mid_x_r_zero", bus.x_r, 0);
        chk("mid_ovf_zero", bus.ovf, 0);
        repeat (2) @(posedge clk); #1;
        reset = 0;
        out_seen = 0;
        repeat (12) @(negedge clk);
        chk("mid_no_output", out_seen, 0);
        chk("mid_in_ready", bus.in_ready, 1);
        @(posedge clk); #1;
        run_one(mk(1000, 200, 400, -100, 32767, 0, 0, 0), 1400, 100, 600, 300, "post_reset");
        chk("final_queue_empty", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
